// File: rtl/npc_pc_unit_if.sv
// Purpose : bundles the control inputs and PC outputs of the program-counter stage.
// Latency : none, wiring only.
// Backpr. : stall travels from the pipeline into the PC unit and freezes it.
//
// Ports (as seen by the PC unit, slave modport):
//   in : stall, is_branch, if_branch, is_j, is_jr, imm16, instr_index, rs_data
//   out: pc, pc_plus4, link_addr, pc_misaligned, redirect_pending
interface npc_pc_unit_if;
  // Decoder / comparator side
  logic        stall;
  logic        is_branch;
  logic        if_branch;
  logic        is_j;
  logic        is_jr;
  logic [15:0] imm16;
  logic [25:0] instr_index;
  logic [31:0] rs_data;

  // PC unit side
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] link_addr;
  logic        pc_misaligned;
  logic        redirect_pending;

  // Upstream pipeline: drives the controls and observes the PC.
  modport master (
    output stall, is_branch, if_branch, is_j, is_jr, imm16, instr_index, rs_data,
    input  pc, pc_plus4, link_addr, pc_misaligned, redirect_pending
  );

  // PC unit: consumes the controls and produces the PC.
  modport slave (
    input  stall, is_branch, if_branch, is_j, is_jr, imm16, instr_index, rs_data,
    output pc, pc_plus4, link_addr, pc_misaligned, redirect_pending
  );
endinterface

// File: rtl/npc_pc_unit.sv
// Purpose : next-PC selection and PC register for the fetch stage, with optional delay slot.
// Latency : redirect visible on pc 1 edge after the decision (2 unstalled edges with delay slot).
// Backpr. : stall freezes pc, redirect state and latched target; inputs are re-evaluated afterwards.
//
// Ports:
//   clk    - rising-edge clock
//   reset  - synchronous active-high reset; overrides stall and aborts a pending redirect
//   bus    - npc_pc_unit_if.slave: controls in, pc / pc_plus4 / link_addr / flags out
module npc_pc_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter bit          DELAY_SLOT = 1'b0
) (
  input logic           clk,
  input logic           reset,
  npc_pc_unit_if.slave  bus
);

  typedef enum logic [0:0] {
    ST_NORMAL  = 1'b0,
    ST_PENDING = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] tgt_q, tgt_d;

  logic [31:0] pc_plus4;
  logic [31:0] br_off;
  logic [31:0] br_tgt;
  logic [31:0] j_tgt;
  logic [31:0] target;
  logic        take;

  // Sequential address and the three candidate targets.
  assign pc_plus4 = pc_q + 32'd4;
  assign br_off   = {{14{bus.imm16[15]}}, bus.imm16, 2'b00};
  assign br_tgt   = pc_plus4 + br_off;
  // Jumps stay inside the 256 MB region of the delay-slot/next instruction.
  assign j_tgt    = {pc_plus4[31:28], bus.instr_index, 2'b00};

  assign take = bus.is_jr | bus.is_j | (bus.is_branch & bus.if_branch);

  // Register jump beats absolute jump beats conditional branch.
  always_comb begin
    target = br_tgt;
    if (bus.is_jr) begin
      target = bus.rs_data;
    end else if (bus.is_j) begin
      target = j_tgt;
    end
  end

  always_comb begin
    pc_d    = pc_q;
    tgt_d   = tgt_q;
    state_d = state_q;
    if (!bus.stall) begin
      if (!DELAY_SLOT) begin
        pc_d = take ? target : pc_plus4;
      end else begin
        case (state_q)
          ST_NORMAL: begin
            // The delay-slot instruction is fetched first; the target waits one update.
            pc_d = pc_plus4;
            if (take) begin
              tgt_d   = target;
              state_d = ST_PENDING;
            end
          end
          ST_PENDING: begin
            // Controls from the delay-slot instruction are deliberately ignored.
            pc_d    = tgt_q;
            state_d = ST_NORMAL;
          end
          default: begin
            pc_d    = pc_plus4;
            state_d = ST_NORMAL;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      tgt_q   <= 32'd0;
      state_q <= ST_NORMAL;
    end else begin
      pc_q    <= pc_d;
      tgt_q   <= tgt_d;
      state_q <= state_d;
    end
  end

  assign bus.pc               = pc_q;
  assign bus.pc_plus4         = pc_plus4;
  // With a delay slot the return must skip over the slot instruction.
  assign bus.link_addr        = DELAY_SLOT ? (pc_q + 32'd8) : pc_plus4;
  assign bus.pc_misaligned    = |pc_q[1:0];
  assign bus.redirect_pending = (state_q == ST_PENDING);

endmodule

// File: tb/tb_npc_pc_unit.sv
// Purpose : exercises both delay-slot variants of npc_pc_unit against a queue-based PC model.
// Latency : model updates on the same rising edge as the DUTs; outputs compared on the falling edge.
// Backpr. : random stall and reset are mixed into the stimulus.
module tb_npc_pc_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;

  logic clk;
  logic rst0, rst1;
  logic chk_en;
  int   n_tests;
  int   n_fail;

  npc_pc_unit_if b0 ();
  npc_pc_unit_if b1 ();

  npc_pc_unit #(.RESET_PC(RESET_PC), .DELAY_SLOT(1'b0)) dut0 (
    .clk   (clk),
    .reset (rst0),
    .bus   (b0)
  );

  npc_pc_unit #(.RESET_PC(RESET_PC), .DELAY_SLOT(1'b1)) dut1 (
    .clk   (clk),
    .reset (rst1),
    .bus   (b1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_pc0;
  logic [31:0] m_pc1;
  logic [31:0] m_q1[$];   // redirect scheduled to land after the delay slot

  // Returns {take, address to use if taken}.
  function automatic logic [32:0] redirect(input logic [31:0] pc, input logic br,
                                           input logic ifb, input logic j, input logic jr,
                                           input logic [15:0] imm, input logic [25:0] idx,
                                           input logic [31:0] rs);
    logic [31:0] seq;
    int          off;
    seq = pc + 32'd4;
    if (jr) return {1'b1, rs};
    if (j)  return {1'b1, (seq & 32'hF000_0000) | ({6'd0, idx} * 32'd4)};
    if (br && ifb) begin
      off = $signed(imm);
      off = off * 4;
      return {1'b1, seq + off};
    end
    return {1'b0, seq};
  endfunction

  always @(posedge clk) begin
    logic [32:0] r;
    if (rst0) begin
      m_pc0 = RESET_PC;
    end else if (!b0.stall) begin
      r = redirect(m_pc0, b0.is_branch, b0.if_branch, b0.is_j, b0.is_jr,
                   b0.imm16, b0.instr_index, b0.rs_data);
      m_pc0 = r[31:0];
    end
    if (rst1) begin
      m_pc1 = RESET_PC;
      m_q1.delete();
    end else if (!b1.stall) begin
      if (m_q1.size() != 0) begin
        m_pc1 = m_q1.pop_front();
      end else begin
        r = redirect(m_pc1, b1.is_branch, b1.if_branch, b1.is_j, b1.is_jr,
                     b1.imm16, b1.instr_index, b1.rs_data);
        if (r[32]) m_q1.push_back(r[31:0]);
        m_pc1 = m_pc1 + 32'd4;
      end
    end
  end

  // ---------------- per-cycle comparison ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      check("ds0_pc",   b0.pc,        m_pc0);
      check("ds0_pc4",  b0.pc_plus4,  m_pc0 + 32'd4);
      check("ds0_link", b0.link_addr, m_pc0 + 32'd4);
      check("ds0_mis",  {31'd0, b0.pc_misaligned},    {31'd0, (m_pc0 % 4) != 0});
      check("ds0_pend", {31'd0, b0.redirect_pending}, 32'd0);
      check("ds1_pc",   b1.pc,        m_pc1);
      check("ds1_pc4",  b1.pc_plus4,  m_pc1 + 32'd4);
      check("ds1_link", b1.link_addr, m_pc1 + 32'd8);
      check("ds1_mis",  {31'd0, b1.pc_misaligned},    {31'd0, (m_pc1 % 4) != 0});
      check("ds1_pend", {31'd0, b1.redirect_pending}, {31'd0, m_q1.size() != 0});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input int d, input logic st, input logic br, input logic ifb,
                       input logic j, input logic jr, input logic [15:0] imm,
                       input logic [25:0] idx, input logic [31:0] rs);
    if (d == 0) begin
      b0.stall = st; b0.is_branch = br; b0.if_branch = ifb; b0.is_j = j; b0.is_jr = jr;
      b0.imm16 = imm; b0.instr_index = idx; b0.rs_data = rs;
    end else begin
      b1.stall = st; b1.is_branch = br; b1.if_branch = ifb; b1.is_j = j; b1.is_jr = jr;
      b1.imm16 = imm; b1.instr_index = idx; b1.rs_data = rs;
    end
  endtask

  task automatic idle(input int d);
    drive(d, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 26'd0, 32'd0);
  endtask

  // One rising edge, returning on the following falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic rand_drive(input int d);
    logic [31:0] rs;
    rs = $urandom();
    if ($urandom_range(0, 3) != 0) rs[1:0] = 2'b00;
    drive(d, ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
          ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
          16'($urandom()), 26'($urandom()), rs);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    chk_en  = 1'b0;
    rst0    = 1'b1;
    rst1    = 1'b1;
    idle(0);
    idle(1);
    tick();
    chk_en = 1'b1;

    // Reset values.
    check("rst_pc0",   b0.pc,        32'h0000_3000);
    check("rst_pc4_0", b0.pc_plus4,  32'h0000_3004);
    check("rst_link0", b0.link_addr, 32'h0000_3004);
    check("rst_link1", b1.link_addr, 32'h0000_3008);
    check("rst_pend1", {31'd0, b1.redirect_pending}, 32'd0);
    check("rst_mis1",  {31'd0, b1.pc_misaligned},    32'd0);

    // Sequential flow on both variants.
    rst0 = 1'b0;
    rst1 = 1'b0;
    tick(); check("seq_pc0_a", b0.pc, 32'h0000_3004); check("seq_pc1_a", b1.pc, 32'h0000_3004);
    tick(); check("seq_pc0_b", b0.pc, 32'h0000_3008);
    tick(); check("seq_pc0_c", b0.pc, 32'h0000_300C); check("seq_link0", b0.link_addr, 32'h0000_3010);
    tick(); check("seq_pc0_d", b0.pc, 32'h0000_3010);

    // Backward branch taken, then not taken from the same pc.
    drive(0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'hFFFC, 26'd0, 32'd0);
    tick(); check("br_taken", b0.pc, 32'h0000_3004);
    idle(0);
    tick(); tick(); tick(); check("br_back", b0.pc, 32'h0000_3010);
    drive(0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'hFFFC, 26'd0, 32'd0);
    tick(); check("br_not", b0.pc, 32'h0000_3014);

    // Stall holds the pc and discards the jr target.
    drive(0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'd0, 26'd0, 32'h0000_8000);
    tick(); check("ds0_stall", b0.pc, 32'h0000_3014);

    // Jump beats branch, jr lands misaligned.
    idle(0);
    rst0 = 1'b1;
    tick(); check("rst0_again", b0.pc, 32'h0000_3000);
    rst0 = 1'b0;
    drive(0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0010, 26'h0000C40, 32'd0);
    tick(); check("j_over_br", b0.pc, 32'h0000_3100);
    drive(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd0, 26'd0, 32'h0000_3202);
    tick(); check("jr_pc", b0.pc, 32'h0000_3202);
    check("jr_mis", {31'd0, b0.pc_misaligned}, 32'd1);

    // Wrap-around at the top of the address space.
    drive(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd0, 26'd0, 32'hFFFF_FFFC);
    tick(); check("wrap_top", b0.pc, 32'hFFFF_FFFC); check("wrap_pc4", b0.pc_plus4, 32'h0000_0000);
    idle(0);
    tick(); check("wrap_zero", b0.pc, 32'h0000_0000);

    // Delay slot: jr executes the slot, later jump in the slot is ignored.
    rst1 = 1'b1;
    tick();
    rst1 = 1'b0;
    drive(1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd0, 26'd0, 32'h0000_4000);
    tick(); check("ds1_slot", b1.pc, 32'h0000_3004);
    check("ds1_slot_pend", {31'd0, b1.redirect_pending}, 32'd1);
    drive(1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0, 26'd0, 32'd0);
    tick(); check("ds1_land", b1.pc, 32'h0000_4000);
    check("ds1_land_pend", {31'd0, b1.redirect_pending}, 32'd0);

    // Delay slot with stall while pending.
    idle(1);
    rst1 = 1'b1;
    tick();
    rst1 = 1'b0;
    drive(1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0, 26'h0001400, 32'd0);
    tick(); check("ds1_st_slot", b1.pc, 32'h0000_3004);
    drive(1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 26'd0, 32'd0);
    tick(); check("ds1_st_hold1", b1.pc, 32'h0000_3004);
    tick(); check("ds1_st_hold2", b1.pc, 32'h0000_3004);
    check("ds1_st_pend", {31'd0, b1.redirect_pending}, 32'd1);
    idle(1);
    tick(); check("ds1_st_land", b1.pc, 32'h0000_5000);

    // Reset aborts a pending redirect.
    rst1 = 1'b1;
    tick();
    rst1 = 1'b0;
    drive(1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0, 26'h0001400, 32'd0);
    tick(); check("abort_slot", b1.pc, 32'h0000_3004);
    idle(1);
    rst1 = 1'b1;
    tick(); check("abort_rst", b1.pc, 32'h0000_3000);
    check("abort_pend", {31'd0, b1.redirect_pending}, 32'd0);
    rst1 = 1'b0;
    tick(); check("abort_seq1", b1.pc, 32'h0000_3004);
    tick(); check("abort_seq2", b1.pc, 32'h0000_3008);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      rand_drive(0);
      rand_drive(1);
      rst0 = ($urandom_range(0, 63) == 0);
      rst1 = ($urandom_range(0, 63) == 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/npc_pc_unit.md
Name: npc_pc_unit

Overview:
- Program-counter stage of the MIPS datapath, directly downstream of the branch comparator.
- Consumes the comparator's taken decision plus decoded jump controls, computes the next PC, and holds the PC register that addresses instruction memory.
- Optionally implements a one-instruction branch delay slot through a two-state redirect machine.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- DELAY_SLOT, 0, 0 = redirect takes effect on the next PC update; 1 = one delay-slot instruction executes before redirect.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- stall  input  1  1 = hold PC and FSM state this cycle.
- is_branch  input  1  current instruction is a conditional branch (beq/bne/bgez/bgtz/blez/bltz).
- if_branch  input  1  branch comparator result; meaningful only with is_branch.
- is_j  input  1  current instruction is j or jal.
- is_jr  input  1  current instruction is jr or jalr.
- imm16  input  16  branch offset field.
- instr_index  input  26  jump target field.
- rs_data  input  32  register value for jr/jalr.
- pc  output  32  current PC (instruction fetch address).
- pc_plus4  output  32  pc + 4.
- link_addr  output  32  return address for jal/jalr.
- pc_misaligned  output  1  pc[1:0] != 0.
- redirect_pending  output  1  FSM is in PENDING (delay-slot instruction in flight).

Behaviour:
- Reset: pc = RESET_PC, FSM = NORMAL, internal target register = 0. Consequently redirect_pending = 0, pc_plus4 = RESET_PC + 4, pc_misaligned = 0, and link_addr = RESET_PC + 4 (DELAY_SLOT = 0) or RESET_PC + 8 (DELAY_SLOT = 1). Reset has priority over stall and over any pending redirect; it aborts that redirect.
- Combinational outputs:
  - pc_plus4 = pc + 4, 32-bit, wraps modulo 2^32.
  - link_addr = pc + 4 if DELAY_SLOT = 0, else pc + 8.
  - pc_misaligned and redirect_pending are combinational from pc and the FSM state.
- Target computation (all 32-bit, modulo 2^32):
  - Branch: pc + 4 + (sign_extend(imm16) << 2).
  - Jump: {pc_plus4[31:28], instr_index, 2'b00}.
  - Register: rs_data, taken unmodified. Misaligned values are accepted into pc and flagged.
- Redirect request:
  - take = is_jr | is_j | (is_branch & if_branch).
  - Priority when several controls are high: is_jr > is_j > branch.
  - is_branch with if_branch = 0 gives sequential flow.
- DELAY_SLOT = 0 (FSM stays in NORMAL): each unstalled edge loads pc = take ? target : pc + 4.
- DELAY_SLOT = 1, FSM states NORMAL and PENDING:
  - NORMAL, take = 0: pc <= pc + 4.
  - NORMAL, take = 1: target_reg <= target; pc <= pc + 4 (delay slot); state <= PENDING.
  - PENDING: pc <= target_reg; state <= NORMAL. All control inputs are ignored in this state, so a branch or jump in a delay slot is architecturally unsupported and has no effect.
- Stall: when stall = 1, pc, state and target_reg all hold. Target computation during a stall is discarded. The request is re-evaluated on the first unstalled edge using the inputs present then.
- Latency: a redirect is visible on pc 1 edge after the decision (DELAY_SLOT = 0) or 2 unstalled edges after it (DELAY_SLOT = 1).
- Wrap-around: pc = 32'hFFFF_FFFC with sequential flow gives pc = 0.

Test Plan:
- Reset then 3 unstalled edges, no controls -> pc sequence 0x3000, 0x3004, 0x3008, 0x300C; link_addr = 0x3010 at 0x300C with DELAY_SLOT = 0.
- DELAY_SLOT = 0; pc = 0x3010, is_branch = 1, if_branch = 1, imm16 = 0xFFFC -> next pc = 0x3004. Same with if_branch = 0 -> 0x3014.
- DELAY_SLOT = 0; pc = 0x3000, is_j = 1, is_branch = 1, if_branch = 1, instr_index = 0x0000C40 -> pc = 0x0000_3100 (jump wins over branch). Then is_jr = 1, rs_data = 0x3202 -> pc = 0x3202, pc_misaligned = 1.
- DELAY_SLOT = 1; pc = 0x3000, is_jr = 1, rs_data = 0x4000 -> next pc = 0x3004 with redirect_pending = 1. Drive is_j = 1, instr_index = 0 during PENDING -> next pc = 0x4000, redirect_pending = 0.
- DELAY_SLOT = 1; take in NORMAL at pc = 0x3000, target 0x5000; stall = 1 for 2 cycles while in PENDING -> pc holds 0x3004; first unstalled edge -> 0x5000. Assert reset while PENDING -> pc = 0x3000, redirect_pending = 0, and no later jump to 0x5000.
- Force pc = 0xFFFF_FFFC by jr, then one sequential edge -> pc = 0x0000_0000.
